fifo_test_sequencer: RTL and testbench

FIFO_TEST_SEQUENCER -- requirements
Module: fifo_test_sequencer

---
 rtl/fifo_test_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_fifo_test_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_test_sequencer.sv
// Fill/dwell/drain exerciser for a FIFO: writes DEPTH LFSR words, waits, reads and checks them.
// Define SEQ_ERR_COUNT_EN to expose a saturating mismatch count on err_cnt.
module fifo_test_sequencer #(
    parameter int unsigned DSIZE   = 8,
    parameter int unsigned ASIZE   = 4,
    parameter int unsigned GAP     = 0,
    parameter logic [15:0] SEED    = 16'hACE1,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             wfull,
    input  logic             rempty,
    input  logic [DSIZE-1:0] rdata,
    output logic             winc,
    output logic             rinc,
    output logic [DSIZE-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [7:0]       err_cnt
);
    localparam int unsigned DEPTH = 1 << ASIZE;
    localparam int unsigned CW    = ASIZE + 1;
    localparam int unsigned GW    = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam int unsigned TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {StIdle, StFill, StDwell, StDrain, StDone, StErr} state_t;

    state_t          state_q, state_d;
    logic [15:0]     wr_lfsr_q, wr_lfsr_d, rd_lfsr_q, rd_lfsr_d;
    logic [CW-1:0]   wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d, dwell_q, dwell_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [TW-1:0]   stall_q, stall_d;
    logic            full_seen_q, full_seen_d, pass_q, pass_d, timeout_q, timeout_d;
    logic            mismatch, err_clr, err_any;

    function automatic logic [15:0] lfsr_step(input logic [15:0] q);
        return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            wr_lfsr_q   <= SEED;
            rd_lfsr_q   <= SEED;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            dwell_q     <= '0;
            gap_q       <= '0;
            stall_q     <= '0;
            full_seen_q <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_lfsr_q   <= wr_lfsr_d;
            rd_lfsr_q   <= rd_lfsr_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            dwell_q     <= dwell_d;
            gap_q       <= gap_d;
            stall_q     <= stall_d;
            full_seen_q <= full_seen_d;
            pass_q      <= pass_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_lfsr_d   = wr_lfsr_q;
        rd_lfsr_d   = rd_lfsr_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        dwell_d     = dwell_q;
        gap_d       = (gap_q != '0) ? gap_q - GW'(1) : gap_q;
        stall_d     = stall_q;
        full_seen_d = full_seen_q;
        pass_d      = pass_q;
        timeout_d   = timeout_q;
        winc        = 1'b0;
        rinc        = 1'b0;
        mismatch    = 1'b0;
        err_clr     = 1'b0;
        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (start) begin
                    state_d     = StFill;
                    wr_lfsr_d   = SEED;
                    rd_lfsr_d   = SEED;
                    wr_cnt_d    = '0;
                    rd_cnt_d    = '0;
                    dwell_d     = '0;
                    gap_d       = '0;
                    stall_d     = '0;
                    full_seen_d = 1'b0;
                    pass_d      = 1'b0;
                    timeout_d   = 1'b0;
                    err_clr     = 1'b1;
                end
            end
            StFill: begin
                if (wfull) begin
                    if (stall_q == TW'(TIMEOUT - 1)) begin
                        state_d   = StErr;
                        timeout_d = 1'b1;
                        pass_d    = 1'b0;
                    end else begin
                        stall_d = stall_q + TW'(1);
                    end
                end else begin
                    stall_d = '0;
                    if (gap_q == '0) begin
                        winc      = 1'b1;
                        wr_lfsr_d = lfsr_step(wr_lfsr_q);
                        wr_cnt_d  = wr_cnt_q + CW'(1);
                        gap_d     = GW'(GAP);
                        if (wr_cnt_q == CW'(DEPTH - 1)) begin
                            state_d = StDwell;
                            dwell_d = '0;
                        end
                    end
                end
            end
            StDwell: begin
                // The full flag is judged once the last write has landed in the FIFO.
                if (dwell_q == '0) full_seen_d = wfull;
                if (dwell_q == CW'(2 * DEPTH - 1)) state_d = StDrain;
                else dwell_d = dwell_q + CW'(1);
            end
            StDrain: begin
                if (rempty) begin
                    if (stall_q == TW'(TIMEOUT - 1)) begin
                        state_d   = StErr;
                        timeout_d = 1'b1;
                        pass_d    = 1'b0;
                    end else begin
                        stall_d = stall_q + TW'(1);
                    end
                end else begin
                    stall_d = '0;
                    if (gap_q == '0) begin
                        rinc      = 1'b1;
                        mismatch  = (rdata != rd_lfsr_q[DSIZE-1:0]);
                        rd_lfsr_d = lfsr_step(rd_lfsr_q);
                        rd_cnt_d  = rd_cnt_q + CW'(1);
                        gap_d     = GW'(GAP);
                        if (rd_cnt_q == CW'(DEPTH - 1)) begin
                            state_d = StDone;
                            pass_d  = full_seen_q && !err_any && !mismatch;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

`ifdef SEQ_ERR_COUNT_EN
    logic [7:0] err_cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_cnt_q <= 8'd0;
        else if (err_clr) err_cnt_q <= 8'd0;
        else if (mismatch && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
    end
    assign err_any = (err_cnt_q != 8'd0);
    assign err_cnt = err_cnt_q;
`else
    logic mism_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mism_q <= 1'b0;
        else if (err_clr) mism_q <= 1'b0;
        else if (mismatch) mism_q <= 1'b1;
    end
    assign err_any = mism_q;
    assign err_cnt = 8'd0;
`endif

    // wdata only carries the LFSR word while it is being strobed, so it idles at zero.
    assign wdata   = winc ? wr_lfsr_q[DSIZE-1:0] : '0;
    assign busy    = (state_q == StFill) || (state_q == StDwell) || (state_q == StDrain);
    assign done    = (state_q == StDone);
    assign pass    = pass_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_fifo_test_sequencer.sv
// Scoreboard bench: two sequencer instances (GAP=0/TIMEOUT=100 and GAP=3) each driving a FIFO model.
module tb_fifo_test_sequencer;
    localparam logic [15:0] SEED = 16'hACE1;
`ifdef SEQ_ERR_COUNT_EN
    localparam int ErrExp = 1;
`else
    localparam int ErrExp = 0;
`endif

    typedef struct packed {
        logic       done;
        logic       pass;
        logic       timeout;
        logic [7:0] err;
    } status_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance 0
    logic       start0 = 1'b0, wfull0, rempty0, winc0, rinc0, busy0, done0, pass0, timeout0;
    logic [7:0] rdata0, wdata0, err_cnt0;
    // Instance 1
    logic       start1 = 1'b0, wfull1, rempty1, winc1, rinc1, busy1, done1, pass1, timeout1;
    logic [7:0] rdata1, wdata1, err_cnt1;

    fifo_test_sequencer #(.TIMEOUT(100)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .wfull(wfull0), .rempty(rempty0),
        .rdata(rdata0), .winc(winc0), .rinc(rinc0), .wdata(wdata0), .busy(busy0),
        .done(done0), .pass(pass0), .timeout(timeout0), .err_cnt(err_cnt0)
    );
    fifo_test_sequencer #(.GAP(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .wfull(wfull1), .rempty(rempty1),
        .rdata(rdata1), .winc(winc1), .rinc(rinc1), .wdata(wdata1), .busy(busy1),
        .done(done1), .pass(pass1), .timeout(timeout1), .err_cnt(err_cnt1)
    );

    // FIFO models: 16 words, flags update on the clock after the strobe.
    logic [7:0] mem0 [16];
    logic [7:0] mem1 [16];
    logic [3:0] wp0, rp0, wp1, rp1;
    logic [4:0] cnt0, cnt1;
    logic       force_full = 1'b0;
    logic       corrupt_en = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp0 <= '0; rp0 <= '0; cnt0 <= '0;
            wp1 <= '0; rp1 <= '0; cnt1 <= '0;
        end else begin
            if (winc0) begin mem0[wp0] <= wdata0; wp0 <= wp0 + 4'd1; end
            if (rinc0) rp0 <= rp0 + 4'd1;
            cnt0 <= cnt0 + {4'd0, winc0} - {4'd0, rinc0};
            if (winc1) begin mem1[wp1] <= wdata1; wp1 <= wp1 + 4'd1; end
            if (rinc1) rp1 <= rp1 + 4'd1;
            cnt1 <= cnt1 + {4'd0, winc1} - {4'd0, rinc1};
        end
    end
    assign wfull0  = force_full || (cnt0 == 5'd16);
    assign rempty0 = (cnt0 == 5'd0);
    assign rdata0  = mem0[rp0] ^ {7'd0, corrupt_en && (rp0 == 4'd5)};
    assign wfull1  = (cnt1 == 5'd16);
    assign rempty1 = (cnt1 == 5'd0);
    assign rdata1  = mem1[rp1];

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_w0 [$];
    logic [7:0] exp_w1 [$];
    status_t    exp_s0 [$];
    status_t    exp_s1 [$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at t=%0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s at t=%0t", name, $time);
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], ^(v & 16'hB400)};
    endfunction

    task automatic push_pass(input int inst, input status_t st);
        logic [15:0] v = SEED;
        for (int i = 0; i < 16; i++) begin
            if (inst == 0) exp_w0.push_back(v[7:0]);
            else exp_w1.push_back(v[7:0]);
            v = lfsr_next(v);
        end
        if (inst == 0) exp_s0.push_back(st);
        else exp_s1.push_back(st);
    endtask

    // Per-pass monitor statistics (cleared when a start is accepted).
    int w0n, r0n, b0n, lw0, lr0, w1n, r1n, b1n, lw1, lr1;

    initial begin : monitor
        logic    dp0 = 1'b0, tp0 = 1'b0, dp1 = 1'b0;
        status_t s;
        forever begin
            @(negedge clk);
            if (start0 && !busy0) begin
                w0n = 0; r0n = 0; b0n = 0;
            end else begin
                if (busy0) b0n++;
                if (winc0) begin
                    check("excl0", int'(rinc0), 0);
                    if (w0n == 0) check("first_wdata0", int'(wdata0), 8'hE1);
                    else check("w_space0", cyc - lw0, 1);
                    if (exp_w0.size() == 0) fail_now("wdata0_unexpected");
                    else check("wdata0", int'(wdata0), int'(exp_w0.pop_front()));
                    lw0 = cyc; w0n++;
                end
                if (rinc0) begin
                    if (r0n == 0) check("dwell0", cyc - lw0, 33);
                    else check("r_space0", cyc - lr0, 1);
                    lr0 = cyc; r0n++;
                end
            end
            if ((done0 && !dp0) || (timeout0 && !tp0)) begin
                if (exp_s0.size() == 0) fail_now("status0_unexpected");
                else begin
                    s = exp_s0.pop_front();
                    check("done0", int'(done0), int'(s.done));
                    check("pass0", int'(pass0), int'(s.pass));
                    check("timeout0", int'(timeout0), int'(s.timeout));
                    check("err_cnt0", int'(err_cnt0), int'(s.err));
                end
            end
            dp0 = done0; tp0 = timeout0;

            if (start1 && !busy1) begin
                w1n = 0; r1n = 0; b1n = 0;
            end else begin
                if (busy1) b1n++;
                if (winc1) begin
                    check("excl1", int'(rinc1), 0);
                    if (w1n > 0) check("w_space1", cyc - lw1, 4);
                    if (exp_w1.size() == 0) fail_now("wdata1_unexpected");
                    else check("wdata1", int'(wdata1), int'(exp_w1.pop_front()));
                    lw1 = cyc; w1n++;
                end
                if (rinc1) begin
                    if (r1n == 0) check("dwell1", cyc - lw1, 33);
                    else check("r_space1", cyc - lr1, 4);
                    lr1 = cyc; r1n++;
                end
            end
            if (done1 && !dp1) begin
                if (exp_s1.size() == 0) fail_now("status1_unexpected");
                else begin
                    s = exp_s1.pop_front();
                    check("done1", int'(done1), int'(s.done));
                    check("pass1", int'(pass1), int'(s.pass));
                    check("err_cnt1", int'(err_cnt1), int'(s.err));
                end
            end
            dp1 = done1;
        end
    end

    task automatic pulse_start(input int inst);
        @(posedge clk); #1;
        if (inst == 0) start0 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0; start1 = 1'b0;
    endtask

    task automatic wait_idle(input int inst, input int bound, input string name);
        int n = 0;
        while (((inst == 0) ? busy0 : busy1) && n < bound) begin
            @(posedge clk); #1;
            n++;
        end
        if ((inst == 0) ? busy0 : busy1) fail_now(name);
        @(negedge clk); #1;
    endtask

    task automatic run_normal(input string name, input bit restart_mid_fill);
        push_pass(0, '{done: 1'b1, pass: 1'b1, timeout: 1'b0, err: 8'd0});
        pulse_start(0);
        if (restart_mid_fill) begin
            repeat (4) @(posedge clk);
            #1 start0 = 1'b1;
            @(posedge clk); #1 start0 = 1'b0;
        end
        wait_idle(0, 300, {name, "_wait"});
        check({name, "_writes"}, w0n, 16);
        check({name, "_reads"}, r0n, 16);
        check({name, "_busy_cycles"}, b0n, 64);
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int n;
        #1;
        check("rst_winc", int'(winc0), 0);
        check("rst_rinc", int'(rinc0), 0);
        check("rst_wdata", int'(wdata0), 0);
        check("rst_busy", int'(busy0), 0);
        check("rst_flags", int'({done0, pass0, timeout0}), 0);
        check("rst_err_cnt", int'(err_cnt0), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("idle_after_reset", int'(busy0), 0);

        run_normal("basic", 1'b0);
        check("basic_done_held", int'(done0), 1);
        run_normal("start_in_fill", 1'b1);

        // Word 5 read back with bit0 flipped.
        corrupt_en = 1'b1;
        push_pass(0, '{done: 1'b1, pass: 1'b0, timeout: 1'b0, err: 8'(ErrExp)});
        pulse_start(0);
        wait_idle(0, 300, "corrupt_wait");
        corrupt_en = 1'b0;
        check("corrupt_done", int'(done0), 1);
        check("corrupt_reads", r0n, 16);

        // FIFO stuck full: 100 blocked FILL cycles, then ERR.
        force_full = 1'b1;
        exp_s0.push_back('{done: 1'b0, pass: 1'b0, timeout: 1'b1, err: 8'd0});
        pulse_start(0);
        wait_idle(0, 300, "timeout_wait");
        check("timeout_writes", w0n, 0);
        check("timeout_busy_cycles", b0n, 100);
        check("timeout_flag", int'(timeout0), 1);
        check("timeout_pass", int'(pass0), 0);
        repeat (5) @(posedge clk);
        #1 check("err_held", int'(timeout0), 1);
        force_full = 1'b0;

        // Restart from ERR, then reset while the 8th read is strobed.
        push_pass(0, '{done: 1'b0, pass: 1'b0, timeout: 1'b0, err: 8'd0});
        void'(exp_s0.pop_back());
        pulse_start(0);
        n = 0;
        while (!(rinc0 && r0n == 7) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("reached_read8", int'(rinc0 && r0n == 7), 1);
        rst_n = 1'b0;
        #1;
        check("abort_winc", int'(winc0), 0);
        check("abort_rinc", int'(rinc0), 0);
        check("abort_busy", int'(busy0), 0);
        check("abort_wdata", int'(wdata0), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1 check("abort_stays_idle", int'(busy0), 0);
        check("abort_w_consumed", exp_w0.size(), 0);
        run_normal("replay", 1'b0);

        // GAP=3 instance: monitor checks 4-cycle spacing on both strobes.
        push_pass(1, '{done: 1'b1, pass: 1'b1, timeout: 1'b0, err: 8'd0});
        pulse_start(1);
        wait_idle(1, 400, "gap_wait");
        check("gap_writes", w1n, 16);
        check("gap_reads", r1n, 16);
        check("gap_busy_cycles", b1n, 154);

        repeat (2) @(posedge clk);
        check("w0_left", exp_w0.size(), 0);
        check("s0_left", exp_s0.size(), 0);
        check("w1_left", exp_w1.size(), 0);
        check("s1_left", exp_s1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
